// File: rtl/hilo_md_seq_pkg.sv
// hilo_pkg: shared definitions for the HI/LO multiply/divide sequencer.
//   - operation codes presented on the op bus
//   - FSM state encoding
//   - default iteration count (operand width)
//   - small helpers for op decode and conditional absolute value
package hilo_pkg;

    localparam int unsigned ITER_DEFAULT = 32;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } md_state_e;

    // True for the four multi-cycle operations (MULT/MULTU/DIV/DIVU).
    function automatic logic is_md_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Magnitude of v when en is set (signed ops); passthrough otherwise.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic en);
        return (en && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/hilo_md_seq_if.sv
// hilo_md_seq_if: Exec-stage <-> HI/LO sequencer bus.
//   master (Exec):      drives start, op, srcA, srcB, flush; sees stall, busy, hi, lo
//   slave (sequencer):  the reverse
interface hilo_md_seq_if;

    logic        start;
    logic [2:0]  op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        flush;
    logic        stall;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, srcA, srcB, flush,
        input  stall, busy, hi, lo
    );

    modport slave (
        input  start, op, srcA, srcB, flush,
        output stall, busy, hi, lo
    );

endinterface

// File: rtl/hilo_md_seq_md_iter_step.sv
// md_iter_step: one iteration of the multiply/divide datapath.
//   i_mode    0 = shift-add multiply, 1 = restoring divide
//   i_acc     64-bit working accumulator
//              multiply: {partial product, remaining multiplier bits}
//              divide:   {partial remainder, remaining dividend / quotient bits}
//   i_operand multiplicand (multiply) or divisor (divide), magnitudes
//   o_acc     accumulator after this iteration
module md_iter_step (
    input  logic        i_mode,
    input  logic [63:0] i_acc,
    input  logic [31:0] i_operand,
    output logic [63:0] o_acc
);

    logic [32:0] w_mul_sum;
    logic [32:0] w_mul_hi;
    logic [32:0] w_div_rem;
    logic [33:0] w_div_diff;
    logic        w_div_ge;
    logic [31:0] w_div_new_rem;

    always_comb begin
        // Multiply: add multiplicand when the multiplier LSB is set, then shift right.
        w_mul_sum = {1'b0, i_acc[63:32]} + {1'b0, i_operand};
        w_mul_hi  = i_acc[0] ? w_mul_sum : {1'b0, i_acc[63:32]};

        // Divide: shift next dividend bit into the remainder, try subtracting the divisor.
        w_div_rem     = {i_acc[63:32], i_acc[31]};
        w_div_diff    = {1'b0, w_div_rem} - {2'b00, i_operand};
        w_div_ge      = ~w_div_diff[33];
        // Either branch is below the divisor, so 32 bits always hold it.
        w_div_new_rem = w_div_ge ? w_div_diff[31:0] : w_div_rem[31:0];

        if (i_mode) begin
            o_acc = {w_div_new_rem, i_acc[30:0], w_div_ge};
        end else begin
            o_acc = {w_mul_hi, i_acc[31:1]};
        end
    end

endmodule

// File: rtl/hilo_md_seq.sv
// hilo_md_seq: multi-cycle multiply/divide sequencer owning HI/LO.
//   clk    rising-edge clock
//   reset  asynchronous active-high; clears FSM, counter and HI/LO
//   md     hilo_md_seq_if.slave: start/op/srcA/srcB/flush in, stall/busy/hi/lo out
// Optional feature: define HILO_FAST_MUL_EN for a single-cycle multiplier
// (MULT/MULTU go IDLE->DONE); divide stays iterative.
module hilo_md_seq
    import hilo_pkg::*;
#(
    parameter int unsigned ITER = ITER_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    hilo_md_seq_if.slave md
);

    localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    md_state_e          r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [63:0]        r_acc, w_acc_nxt;
    logic [31:0]        r_operand, w_operand_nxt;
    logic               r_is_div, w_is_div_nxt;
    logic               r_neg_q, w_neg_q_nxt;   // negate product (mult) or quotient (div)
    logic               r_neg_r, w_neg_r_nxt;   // negate remainder (div only)
    logic [31:0]        r_hi, w_hi_nxt;
    logic [31:0]        r_lo, w_lo_nxt;

    logic               w_accept;
    logic               w_md_op;
    logic               w_signed;
    logic               w_div_op;
    logic               w_div_zero;
    logic [31:0]        w_abs_a;
    logic [31:0]        w_abs_b;
    logic [63:0]        w_step_acc;
    logic [63:0]        w_prod_fix;
    logic [31:0]        w_quo_fix;
    logic [31:0]        w_rem_fix;
`ifdef HILO_FAST_MUL_EN
    logic [63:0]        w_fast_prod;
`endif

    md_iter_step u_step (
        .i_mode    (r_is_div),
        .i_acc     (r_acc),
        .i_operand (r_operand),
        .o_acc     (w_step_acc)
    );

    always_comb begin
        w_md_op    = is_md_op(md.op);
        w_signed   = (md.op == MD_MULT) || (md.op == MD_DIV);
        w_div_op   = (md.op == MD_DIV) || (md.op == MD_DIVU);
        w_div_zero = w_div_op && (md.srcB == 32'd0);
        w_abs_a    = abs32(md.srcA, w_signed);
        w_abs_b    = abs32(md.srcB, w_signed);
        w_accept   = (r_state == IDLE) && md.start && !md.flush;

        w_prod_fix = r_neg_q ? (64'd0 - r_acc) : r_acc;
        w_quo_fix  = r_neg_q ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
        w_rem_fix  = r_neg_r ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
    end

`ifdef HILO_FAST_MUL_EN
    always_comb begin
        if (md.op == MD_MULT) begin
            w_fast_prod = $signed({{32{md.srcA[31]}}, md.srcA})
                        * $signed({{32{md.srcB[31]}}, md.srcB});
        end else begin
            w_fast_prod = {32'd0, md.srcA} * {32'd0, md.srcB};
        end
    end
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_acc_nxt     = r_acc;
        w_operand_nxt = r_operand;
        w_is_div_nxt  = r_is_div;
        w_neg_q_nxt   = r_neg_q;
        w_neg_r_nxt   = r_neg_r;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;

        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (md.op == MD_MTHI) begin
                        w_hi_nxt = md.srcA;
                    end else if (md.op == MD_MTLO) begin
                        w_lo_nxt = md.srcA;
                    end else if (w_md_op) begin
                        w_cnt_nxt    = '0;
                        w_is_div_nxt = w_div_op;
                        w_neg_q_nxt  = w_signed && (md.srcA[31] ^ md.srcB[31]);
                        w_neg_r_nxt  = w_signed && w_div_op && md.srcA[31];
                        if (w_div_zero) begin
                            // Layout matches {remainder, quotient}; no fix-up applied.
                            w_acc_nxt   = {md.srcA, 32'hFFFF_FFFF};
                            w_neg_q_nxt = 1'b0;
                            w_neg_r_nxt = 1'b0;
                            w_state_nxt = DONE;
                        end else if (w_div_op) begin
                            w_acc_nxt     = {32'd0, w_abs_a};
                            w_operand_nxt = w_abs_b;
                            w_state_nxt   = RUN;
                        end else begin
`ifdef HILO_FAST_MUL_EN
                            w_acc_nxt   = w_fast_prod;
                            w_neg_q_nxt = 1'b0;
                            w_state_nxt = DONE;
`else
                            w_acc_nxt     = {32'd0, w_abs_b};
                            w_operand_nxt = w_abs_a;
                            w_state_nxt   = RUN;
`endif
                        end
                    end
                end
            end
            RUN: begin
                if (md.flush) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_acc_nxt = w_step_acc;
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(ITER - 1)) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                // A flush on the writeback edge suppresses the write.
                if (!md.flush) begin
                    if (r_is_div) begin
                        w_hi_nxt = w_rem_fix;
                        w_lo_nxt = w_quo_fix;
                    end else begin
                        w_hi_nxt = w_prod_fix[63:32];
                        w_lo_nxt = w_prod_fix[31:0];
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_operand <= '0;
            r_is_div  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_acc     <= w_acc_nxt;
            r_operand <= w_operand_nxt;
            r_is_div  <= w_is_div_nxt;
            r_neg_q   <= w_neg_q_nxt;
            r_neg_r   <= w_neg_r_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
        end
    end

    assign md.busy  = (r_state != IDLE);
    assign md.stall = md.busy || (md.start && w_md_op && !md.flush);
    assign md.hi    = r_hi;
    assign md.lo    = r_lo;

endmodule

// File: tb/tb_hilo_md_seq.sv
// tb_hilo_md_seq: directed + small random bench for hilo_md_seq.
// Expected {hi, lo} pairs are queued when an operation is issued and
// popped when the sequencer drops busy. Inputs change and outputs are
// sampled on the falling clock edge (mid-cycle).
module tb_hilo_md_seq;
    import hilo_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    hilo_md_seq_if bus ();

    hilo_md_seq #(
        .ITER (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic f);
        bus.start = s;
        bus.op    = o;
        bus.srcA  = a;
        bus.srcB  = b;
        bus.flush = f;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Reference result {hi, lo} computed arithmetically.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        q;
        logic [31:0]        r;
        sa = a;
        sb = b;
        case (o)
            MD_MULT:  return $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            MD_MULTU: return {32'd0, a} * {32'd0, b};
            MD_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] o, input logic [31:0] b);
        if ((o == MD_DIV || o == MD_DIVU) && b == 32'd0) return 2;
`ifdef HILO_FAST_MUL_EN
        if (o == MD_MULT || o == MD_MULTU) return 2;
`endif
        return 34;
    endfunction

    // Issue one op at the current cycle (cycle 0), check stall/busy each
    // cycle, then pop and compare the result when readable.
    task automatic run_md(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        int          lat;
        logic [63:0] e;
        lat = lat_of(o, b);
        drive(1'b1, o, a, b, 1'b0);
        #1;
        chk({tag, "/c0_busy_stall"}, {bus.busy, bus.stall}, 2'b01);
        exp_q.push_back(exp);
        for (int c = 1; c < lat; c++) begin
            step();
            if (c == 1) bus.start = 1'b0;
            #1;
            chk({tag, "/run_busy_stall"}, {bus.busy, bus.stall}, 2'b11);
        end
        step();
        #1;
        chk({tag, "/end_busy_stall"}, {bus.busy, bus.stall}, 2'b00);
        e = exp_q.pop_front();
        chk({tag, "/hilo"}, {bus.hi, bus.lo}, e);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  flush_op;

        drive(1'b0, MD_MULT, 32'd0, 32'd0, 1'b0);
        step();
        chk("reset_state", {bus.hi, bus.lo, 30'd0, bus.busy, bus.stall}, 64'd0);
        reset = 1'b0;
        step();

        run_md("mult_neg2x3", MD_MULT, 32'hFFFF_FFFE, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
        run_md("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_md("divu_m7_2", MD_DIVU, 32'hFFFF_FFF9, 32'd2, {32'd1, 32'h7FFF_FFFC});
        run_md("divu_by0", MD_DIVU, 32'h1234, 32'd0, {32'h1234, 32'hFFFF_FFFF});

        // MTHI then MTLO back to back: no stall, each readable next cycle.
        drive(1'b1, MD_MTHI, 32'hA5A5_0000, 32'd0, 1'b0);
        #1;
        chk("mthi_stall", bus.stall, 1'b0);
        step();
        drive(1'b1, MD_MTLO, 32'h0000_5A5A, 32'd0, 1'b0);
        #1;
        chk("mtlo_stall", bus.stall, 1'b0);
        chk("mthi_hi", bus.hi, 32'hA5A5_0000);
        step();
        drive(1'b0, MD_MULT, 32'd0, 32'd0, 1'b0);
        #1;
        chk("mtlo_hilo", {bus.hi, bus.lo}, {32'hA5A5_0000, 32'h0000_5A5A});

        // Start together with flush in IDLE is dropped.
        step();
        drive(1'b1, MD_MULT, 32'd5, 32'd5, 1'b1);
        #1;
        chk("start_flush_stall", bus.stall, 1'b0);
        step();
        drive(1'b1, MD_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b1);
        step();
        drive(1'b0, MD_MULT, 32'd0, 32'd0, 1'b0);
        #1;
        chk("start_flush_ignored", {bus.hi, bus.lo, 31'd0, bus.busy},
            {32'hA5A5_0000, 32'h0000_5A5A, 32'd0});

        // Flush during RUN in cycle 10: idle in cycle 11, HI/LO untouched.
`ifdef HILO_FAST_MUL_EN
        flush_op = MD_DIVU;
`else
        flush_op = MD_MULTU;
`endif
        step();
        drive(1'b1, flush_op, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            step();
            if (c == 1) bus.start = 1'b0;
            if (c == 10) bus.flush = 1'b1;
        end
        step();
        bus.flush = 1'b0;
        #1;
        chk("flush_run_busy", {bus.busy, bus.stall}, 2'b00);
        chk("flush_run_hilo", {bus.hi, bus.lo}, {32'hA5A5_0000, 32'h0000_5A5A});

        step();
        run_md("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'd1});

        // Flush coinciding with the DONE edge wins: no write.
        drive(1'b1, MD_DIVU, 32'd100, 32'd7, 1'b0);
        for (int c = 1; c <= 33; c++) begin
            step();
            if (c == 1) bus.start = 1'b0;
            if (c == 33) begin
                #1;
                chk("done_busy", bus.busy, 1'b1);
                bus.flush = 1'b1;
            end
        end
        step();
        bus.flush = 1'b0;
        #1;
        chk("flush_done_hilo", {bus.hi, bus.lo}, {32'hFFFF_FFFE, 32'd1});
        chk("flush_done_busy", bus.busy, 1'b0);

        // Start while busy is ignored; the running divide completes normally.
        step();
        drive(1'b1, MD_DIVU, 32'd100, 32'd7, 1'b0);
        exp_q.push_back({32'd2, 32'd14});
        for (int c = 1; c < 34; c++) begin
            step();
            if (c == 1) bus.start = 1'b0;
            if (c == 5) drive(1'b1, MD_MTHI, 32'h5555_5555, 32'd0, 1'b0);
            if (c == 6) bus.start = 1'b0;
        end
        step();
        #1;
        chk("busy_start_ignored", {bus.hi, bus.lo}, exp_q.pop_front());

        // Asynchronous reset in cycle 5 of a DIV.
        step();
        drive(1'b1, MD_DIV, 32'd1000, 32'd3, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c == 1) bus.start = 1'b0;
        end
        reset = 1'b1;
        #1;
        chk("async_reset", {bus.hi, bus.lo, 30'd0, bus.busy, bus.stall}, 64'd0);
        step();
        reset = 1'b0;
        step();
        run_md("mult_6x7", MD_MULT, 32'd6, 32'd7, {32'd0, 32'd42});

        // A few random operations against the arithmetic model.
        for (int i = 0; i < 6; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i == 2) ? 32'd0 : $urandom;
            if (ro == MD_DIV && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
            run_md("random", ro, ra, rb, model(ro, ra, rb));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
